axis_frame_arb_rr: RTL
======================

AXIS_FRAME_ARB_RR -- requirements
Module: axis_frame_arb_rr

Interface
REQ-001 Parameter: PORTS, default 4, number of AXI-Stream requesters (2..8) sharing one downstream stream.
REQ-002 Parameter: DATA_WIDTH, default 8, tdata width per port.
REQ-003 Parameter: USER_WIDTH, default 1, tuser width per port.
REQ-004 Parameter: TIMEOUT, default 255, mid-frame stall limit in cycles (watchdog build only; 1..65535).
REQ-005 Port: clk  input  1  single clock for all logic.
REQ-006 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-007 Port: s_axis_tdata  input  PORTS*DATA_WIDTH  port i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port: s_axis_tvalid / s_axis_tlast  input  PORTS each  per-port valid / end of frame.
REQ-009 Port: s_axis_tuser  input  PORTS*USER_WIDTH  per-port sideband.
REQ-010 Port: s_axis_tready  output  PORTS  per-port ready.
REQ-011 Port: m_axis_tdata / m_axis_tuser  output  DATA_WIDTH / USER_WIDTH  merged stream.
REQ-012 Port: m_axis_tvalid, m_axis_tlast  output  1 each; m_axis_tready  input  1.
REQ-013 Port: grant  output  PORTS  one-hot owner of the output; zero when idle.
REQ-014 Port: abort_pulse  output  1  one-cycle strobe on watchdog abort (constant 0 without macro).

Function
REQ-015 FSM states: IDLE, XFER, ABORT, DRAIN. ABORT and DRAIN exist only in the watchdog build.
REQ-016 IDLE: when any s_axis_tvalid is high, grant the first requesting port found by scanning upward from (last_grant+1) mod PORTS; then enter XFER on the next cycle.
REQ-017 Arbitration uses one cycle. No s_axis_tready is asserted in IDLE.
REQ-018 Arbitration is frame-level: the grant is held until the granted port's beat with tlast=1 is accepted.
REQ-019 Output is one register stage. s_axis_tready[g] = XFER & (~m_axis_tvalid | m_axis_tready). All other ready bits are 0.
REQ-020 Accepted beats appear on m_axis_* exactly 1 cycle later, with tdata, tlast and tuser unmodified. The output holds steady while m_axis_tvalid=1 and m_axis_tready=0.
REQ-021 Full throughput: with continuous valid and ready, one beat per cycle. An N-beat frame costs N+1 cycles including arbitration.
REQ-022 Acceptance of the tlast beat: last_grant <= g, state -> IDLE, and grant clears in the same edge.
REQ-023 A single-beat frame (tvalid and tlast together) is legal and handled identically.
REQ-024 Requests that drop before they are granted are ignored. No request is latched.
REQ-025 Round-robin fairness: a continuously requesting port waits at most PORTS-1 frames.
REQ-026 last_grant resets to PORTS-1, so port 0 wins the first arbitration.

Reset
REQ-027 Asynchronous assert, synchronous deassert is the system's job.
REQ-028 Reset values: state=IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tuser=0, grant=0, s_axis_tready=0, abort_pulse=0, watchdog count=0.
REQ-029 Reset during XFER discards the partial frame. No tlast is emitted for it.

Configuration
REQ-030 Macro AXIS_FRAME_ARB_RR_WATCHDOG_EN.
REQ-031 With the macro defined:
- In XFER, a counter increments on each cycle where s_axis_tvalid[g]=0.
- The counter clears on every accepted beat.
- When the counter reaches TIMEOUT, enter ABORT.
REQ-032 ABORT: emit one beat with tdata=0, tlast=1, tuser=all-ones; pulse abort_pulse for one cycle; then enter DRAIN once that beat is loaded into the output register.
REQ-033 DRAIN: s_axis_tready[g]=1, with input beats discarded (no output). On acceptance of tlast, go to IDLE and set last_grant=g.
REQ-034 Output back-pressure (m_axis_tready=0) never increments the watchdog.
REQ-035 Without the macro: no counter, ABORT and DRAIN are absent, abort_pulse is tied to 0, and a stalled frame holds the grant indefinitely.

Verification
REQ-036 Ports 0 and 2 each present a 3-beat frame from reset, m_axis_tready=1 -> port 0 frame out on cycles 2-4, port 2 frame on cycles 6-8, grant 0001 then 0100.
REQ-037 All 4 ports continuously requesting 1-beat frames -> grant order 0,1,2,3,0, each beat separated by one idle cycle.
REQ-038 m_axis_tready low for 5 cycles mid-frame -> m_axis_tdata stable, no beat lost or duplicated, grant unchanged.
REQ-039 Port 1 sends 2 of 4 beats, then stalls 300 cycles, TIMEOUT=255, macro on:
- tdata=0, tlast=1, tuser=1 beat emitted after 255 stall cycles; abort_pulse high for 1 cycle.
- Remaining 2 beats consumed without output; port 2 served next.
REQ-040 Same stall, macro off -> output idles, grant stays 0010, no abort_pulse. On resume, beats 3-4 emitted normally.
REQ-041 rst_n asserted mid-frame -> all outputs at reset values immediately, no clock edge required. After release, port 0 has first priority.

Source files
------------

// File: rtl/axis_frame_arb_rr.sv
// Frame-level round-robin arbiter merging PORTS AXI-Stream sources into one registered output.
// Optional build macro AXIS_FRAME_ARB_RR_WATCHDOG_EN adds a mid-frame stall watchdog (ABORT/DRAIN).
module axis_frame_arb_rr #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [PORTS-1:0]            s_axis_tvalid,
  input  logic [PORTS-1:0]            s_axis_tlast,
  input  logic [PORTS*USER_WIDTH-1:0] s_axis_tuser,
  output logic [PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [USER_WIDTH-1:0]       m_axis_tuser,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic [PORTS-1:0]            grant,
  output logic                        abort_pulse
);

  localparam int IDX_W = $clog2(PORTS);

  if (PORTS < 2 || PORTS > 8) begin : g_bad_ports
    $error("axis_frame_arb_rr: PORTS must be in 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("axis_frame_arb_rr: TIMEOUT must be in 1..65535");
  end

`ifdef AXIS_FRAME_ARB_RR_WATCHDOG_EN
  typedef enum logic [1:0] {IDLE, XFER, ABORT, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, XFER} state_t;
`endif

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        gidx_q, gidx_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [PORTS-1:0]        grant_q, grant_d;

  logic                    out_free;
  logic                    sel_valid;
  logic                    sel_last;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [USER_WIDTH-1:0]   sel_user;
  logic                    accept;
  logic                    load_beat;

  logic                    valid_q;
  logic                    last_beat_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [USER_WIDTH-1:0]   user_q;

`ifdef AXIS_FRAME_ARB_RR_WATCHDOG_EN
  logic                    load_abort;
  logic                    abort_q;
  logic [15:0]             cnt_q, cnt_d;
`endif

  // First requester found scanning upward from last+1, wrapping at PORTS.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [PORTS-1:0] req,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] pick;
    int               cand;
    pick = last;
    for (int k = PORTS; k >= 1; k--) begin
      cand = (int'(last) + k) % PORTS;
      if (req[IDX_W'(cand)]) pick = IDX_W'(cand);
    end
    return pick;
  endfunction

  assign out_free  = ~valid_q | m_axis_tready;
  assign sel_valid = s_axis_tvalid[gidx_q];
  assign sel_last  = s_axis_tlast[gidx_q];
  assign sel_data  = s_axis_tdata[gidx_q*DATA_WIDTH +: DATA_WIDTH];
  assign sel_user  = s_axis_tuser[gidx_q*USER_WIDTH +: USER_WIDTH];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the case infers a latch.
    state_d       = state_q;
    gidx_d        = gidx_q;
    last_d        = last_q;
    grant_d       = grant_q;
    s_axis_tready = '0;
    accept        = 1'b0;
    load_beat     = 1'b0;
`ifdef AXIS_FRAME_ARB_RR_WATCHDOG_EN
    load_abort    = 1'b0;
    cnt_d         = '0;
`endif
    case (state_q)
      IDLE: begin
        if (|s_axis_tvalid) begin
          gidx_d  = rr_pick(s_axis_tvalid, last_q);
          grant_d = PORTS'(1) << gidx_d;
          state_d = XFER;
        end
      end
      XFER: begin
        s_axis_tready = grant_q & {PORTS{out_free}};
        accept        = out_free & sel_valid;
        load_beat     = accept;
        if (accept && sel_last) begin
          last_d  = gidx_q;
          grant_d = '0;
          state_d = IDLE;
        end
`ifdef AXIS_FRAME_ARB_RR_WATCHDOG_EN
        else if (!accept) begin
          // Only a silent source counts; a valid beat held off by m_axis_tready does not.
          cnt_d = sel_valid ? cnt_q : cnt_q + 16'd1;
          if (cnt_d == 16'(TIMEOUT)) begin
            cnt_d   = '0;
            state_d = ABORT;
          end
        end
`endif
      end
`ifdef AXIS_FRAME_ARB_RR_WATCHDOG_EN
      ABORT: begin
        if (out_free) begin
          load_abort = 1'b1;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        s_axis_tready = grant_q;
        accept        = sel_valid;
        if (accept && sel_last) begin
          last_d  = gidx_q;
          grant_d = '0;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      last_q  <= IDX_W'(PORTS - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  // Single output register stage; holds its contents while the sink stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      last_beat_q <= 1'b0;
      data_q      <= '0;
      user_q      <= '0;
    end else if (load_beat) begin
      valid_q     <= 1'b1;
      last_beat_q <= sel_last;
      data_q      <= sel_data;
      user_q      <= sel_user;
    end
`ifdef AXIS_FRAME_ARB_RR_WATCHDOG_EN
    else if (load_abort) begin
      valid_q     <= 1'b1;
      last_beat_q <= 1'b1;
      data_q      <= '0;
      user_q      <= '1;
    end
`endif
    else if (m_axis_tready) begin
      valid_q     <= 1'b0;
    end
  end

`ifdef AXIS_FRAME_ARB_RR_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      abort_q <= load_abort;
    end
  end

  assign abort_pulse = abort_q;
`else
  assign abort_pulse = 1'b0;
`endif

  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = last_beat_q;
  assign m_axis_tdata  = data_q;
  assign m_axis_tuser  = user_q;
  assign grant         = grant_q;

endmodule
